// File: rtl/cache_definition.sv
// Shared request/response types between the caches, the arbiter and the
// sram_controller, plus the arbiter state encoding.
package cache_definition;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // rw encoding on the memory bus: 1 = write, 0 = read
  localparam logic RW_WRITE = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cache_to_mem_type;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
  } mem_to_cache_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_type;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping, and returns the first requester with its bit set.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_vec,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  // cand[k] is the requester examined at search position k
  logic [IW-1:0] cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = IW'((32'(last_grant) + 32'(gi) + 32'd1) % 32'(NREQ));
  end

  // Walk from the farthest candidate down so the nearest hit wins
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_vec[cand[i]]) begin
        found = 1'b1;
        index = cand[i];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting NREQ cache requesters share one
// sram_controller. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Every output is a register; the request is latched at grant time so
// requester activity while busy never reaches the memory bus.
module mem_arbiter
  import cache_definition::*;
#(
  parameter int NREQ = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  cache_to_mem_type [NREQ-1:0]      req_in,
  output mem_to_cache_type [NREQ-1:0]      rsp_out,
  output cache_to_mem_type                 mem_req,
  input  mem_to_cache_type                 mem_rsp,
  output logic [$clog2(NREQ)-1:0]          grant_idx,
  output logic                             busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_type               state_reg, state_next;
  cache_to_mem_type            mem_req_reg, mem_req_next;
  mem_to_cache_type [NREQ-1:0] rsp_reg, rsp_next;
  logic [IW-1:0]               grant_reg, grant_next;
  logic [IW-1:0]               last_reg, last_next;
  logic                        busy_reg, busy_next;

  logic [NREQ-1:0] valid_vec;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_valid
    assign valid_vec[gi] = req_in[gi].valid;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_vec    (valid_vec),
    .last_grant (last_reg),
    .found      (pick_found),
    .index      (pick_idx)
  );

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mem_req_reg <= '0;
      rsp_reg     <= '0;
      grant_reg   <= '0;
      last_reg    <= IW'(NREQ - 1);
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= mem_req_next;
      rsp_reg     <= rsp_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      busy_reg    <= busy_next;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_next         = state_reg;
    mem_req_next       = mem_req_reg;
    mem_req_next.valid = 1'b0;
    rsp_next           = rsp_reg;
    for (int j = 0; j < NREQ; j++) begin
      rsp_next[j].ready = 1'b0;
    end
    grant_next = grant_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next         = pick_idx;
          last_next          = pick_idx;
          mem_req_next       = req_in[pick_idx];
          mem_req_next.valid = 1'b1;
          state_next         = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp.ready) begin
          rsp_next[grant_reg].ready = 1'b1;
          rsp_next[grant_reg].data  = (mem_req_reg.rw == RW_WRITE) ? '0 : mem_rsp.data;
          state_next                = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign mem_req   = mem_req_reg;
  assign rsp_out   = rsp_reg;
  assign grant_idx = grant_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NREQ=2) with a behavioural memory that
// answers 2 cycles after mem_req.valid. Each queued request pushes its
// expected issue and response onto scoreboards checked as the DUT acts.
module tb_mem_arbiter;
  import cache_definition::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cache_to_mem_type [NREQ-1:0] req_in;
  mem_to_cache_type [NREQ-1:0] rsp_out;
  cache_to_mem_type            mem_req;
  mem_to_cache_type            mem_rsp;
  logic [0:0]                  grant_idx;
  logic                        busy;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .rsp_out   (rsp_out),
    .mem_req   (mem_req),
    .mem_rsp   (mem_rsp),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_pattern(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
  endfunction

  // Behavioural SRAM: ready one cycle, 2 cycles after valid
  logic [15:0] mem [256];
  bit          mem_init = 1'b0;
  int          mem_cnt  = 0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] = mem_pattern(8'(a));
      mem_init = 1'b1;
    end
    if (!rst) begin
      mem_cnt = 0;
      mem_rsp = '0;
    end else begin
      mem_rsp.ready = 1'b0;
      mem_rsp.data  = 16'hDEAD;
      if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rsp.ready = 1'b1;
          if (mem_req.rw) mem[mem_req.addr[7:0]] = mem_req.data;
          else            mem_rsp.data = mem[mem_req.addr[7:0]];
        end
      end
      if (mem_req.valid) mem_cnt = 2;
    end
  end

  typedef struct {
    int          idx;
    logic        rw;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } op_t;

  op_t pend0[$];
  op_t pend1[$];
  op_t iss_q[$];
  op_t rsp_q[$];
  op_t cur;
  logic [15:0] ref_mem [256];
  int   cycle = 0, issue_cycle = 0, last_ready_cycle = 0, issued = 0;
  logic prev_valid = 1'b0;
  bit   chk_gap = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input int idx, input logic rw, input logic [19:0] addr,
                         input logic [15:0] wdata, input bit expect_rsp);
    op_t o;
    o.idx = idx; o.rw = rw; o.addr = addr; o.wdata = wdata;
    o.rdata = rw ? 16'h0000 : ref_mem[addr[7:0]];
    if (rw) ref_mem[addr[7:0]] = wdata;
    if (idx == 0) pend0.push_back(o); else pend1.push_back(o);
    iss_q.push_back(o);
    if (expect_rsp) rsp_q.push_back(o);
  endtask

  task automatic load_req(input int i);
    op_t o;
    if (i == 0) o = pend0.pop_front(); else o = pend1.pop_front();
    req_in[i].valid = 1'b1;
    req_in[i].rw    = o.rw;
    req_in[i].addr  = o.addr;
    req_in[i].data  = o.wdata;
  endtask

  // One clock: monitor the DUT mid-cycle, then advance the requester models
  task automatic tick();
    op_t e;
    int  nready;
    int  psz;
    @(negedge clk);
    cycle++;
    if (mem_req.valid) begin
      issued++;
      check("issue_single_cycle", 64'(prev_valid), 64'd0);
      check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
      if (iss_q.size() != 0) begin
        e = iss_q.pop_front();
        cur = e;
        check("issue_grant", 64'(grant_idx), 64'(e.idx));
        check("issue_rw", 64'(mem_req.rw), 64'(e.rw));
        check("issue_addr", 64'(mem_req.addr), 64'(e.addr));
        if (e.rw) check("issue_wdata", 64'(mem_req.data), 64'(e.wdata));
        if (chk_gap) check("issue_gap", 64'(cycle - last_ready_cycle), 64'd2);
      end
      issue_cycle = cycle;
    end else if (busy) begin
      check("hold_addr", 64'(mem_req.addr), 64'(cur.addr));
    end
    prev_valid = mem_req.valid;
    nready = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (rsp_out[j].ready) begin
        nready++;
        check("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          $display("rsp: cycle=%0d req=%0d data=%h", cycle, j, rsp_out[j].data);
          check("rsp_idx", 64'(j), 64'(e.idx));
          check("rsp_grant", 64'(grant_idx), 64'(j));
          check("rsp_data", 64'(rsp_out[j].data), 64'(e.rdata));
          check("rsp_latency", 64'(cycle - issue_cycle), 64'd3);
        end
        last_ready_cycle = cycle;
      end
    end
    if (nready > 1) check("ready_onehot", 64'(nready), 64'd1);
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        psz = (i == 0) ? pend0.size() : pend1.size();
        if (req_in[i].valid && rsp_out[i].ready) begin
          if (psz != 0) load_req(i); else req_in[i].valid = 1'b0;
        end else if (!req_in[i].valid && psz != 0) begin
          load_req(i);
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit done;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (pend0.size() == 0) && (pend1.size() == 0) && (rsp_q.size() == 0) &&
             !busy && !req_in[0].valid && !req_in[1].valid;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic wait_issue(input string tag, input int budget);
    int n = 0;
    int base;
    base = issued;
    while (issued == base && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_issue_seen"}, 64'(issued != base), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_grant"}, 64'(grant_idx), 64'd0);
    check({tag, "_rsp0"}, 64'(rsp_out[0]), 64'd0);
    check({tag, "_rsp1"}, 64'(rsp_out[1]), 64'd0);
  endtask

  initial begin
    int base;
    req_in = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem_pattern(8'(a));

    // Power-on reset, checked before and after clock edges
    #2 rst = 1'b0;
    #1 check_reset("por");
    tick();
    tick();
    check_reset("por_clocked");
    rst = 1'b1;

    // Simultaneous: req0 write wins, req1 then reads the written value
    enqueue(0, 1'b1, 20'h00020, 16'h1234, 1'b1);
    enqueue(1, 1'b0, 20'h00020, 16'h0000, 1'b1);
    wait_done("simul", 40);

    // Single read from requester 0
    enqueue(0, 1'b0, 20'h00010, 16'h0000, 1'b1);
    wait_done("single", 20);

    // Payload change during WAIT must not reach mem_req
    enqueue(0, 1'b0, 20'h00030, 16'h0000, 1'b1);
    wait_issue("stab", 10);
    tick();
    req_in[0].addr = 20'h00031;
    wait_done("stab", 20);
    check("stab_final_addr", 64'(mem_req.addr), 64'h00030);

    // Reset during req1 WAIT aborts without any ready
    enqueue(1, 1'b0, 20'h00010, 16'h0000, 1'b0);
    wait_issue("abort", 10);
    tick();
    #2 rst = 1'b0;
    #1 check_reset("abort");
    req_in[1].valid = 1'b0;
    tick();
    tick();
    tick();
    check_reset("abort_held");
    rst = 1'b1;
    enqueue(1, 1'b0, 20'h00010, 16'h0000, 1'b1);
    wait_done("reissue", 20);

    // Back-to-back from req1: reissue right after ready
    base = issued;
    enqueue(1, 1'b1, 20'h00050, 16'hCAFE, 1'b1);
    enqueue(1, 1'b0, 20'h00050, 16'h0000, 1'b1);
    wait_issue("b2b", 10);
    chk_gap = 1'b1;
    wait_done("b2b", 30);
    chk_gap = 1'b0;
    check("b2b_issue_count", 64'(issued - base), 64'd2);

    // Fairness: both requesters continuously valid, grants alternate 0,1,...
    base = issued;
    enqueue(0, 1'b0, 20'h00040, 16'h0000, 1'b1);
    enqueue(1, 1'b1, 20'h00041, 16'h5555, 1'b1);
    enqueue(0, 1'b1, 20'h00040, 16'h7777, 1'b1);
    enqueue(1, 1'b0, 20'h00041, 16'h0000, 1'b1);
    enqueue(0, 1'b0, 20'h00040, 16'h0000, 1'b1);
    enqueue(1, 1'b0, 20'h00010, 16'h0000, 1'b1);
    wait_issue("fair", 10);
    chk_gap = 1'b1;
    wait_done("fair", 80);
    chk_gap = 1'b0;
    check("fair_issue_count", 64'(issued - base), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
